// File: rtl/score_keeper.sv
// score_keeper: game-score accumulator and game-state FSM feeding the score display.
// Turns hit/miss/start level inputs into edge-detected events. Keeps an 8-bit saturating
// score with a combo bonus, a lives counter and the IDLE/PLAYING/GAME_OVER state.
// Optional feature: define SCORE_KEEPER_HIGH_SCORE_EN to add a persistent high_score output.
module score_keeper #(
  parameter int unsigned MAX_SCORE  = 255,
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned POINTS_HIT = 1,
  parameter int unsigned COMBO_LEN  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       playing,
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  output logic       game_over,
  output logic [7:0] high_score
`else
  output logic       game_over
`endif
);

  localparam int unsigned CW = (COMBO_LEN < 1) ? 1 : $clog2(COMBO_LEN + 1);

  localparam logic [8:0]    MaxScore9 = 9'(MAX_SCORE);
  localparam logic [8:0]    IncSingle = 9'(POINTS_HIT);
  localparam logic [8:0]    IncDouble = 9'(2 * POINTS_HIT);
  localparam logic [CW-1:0] ComboMax  = CW'(COMBO_LEN);
  localparam logic [1:0]    LivesInit = 2'(LIVES_INIT);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPlaying  = 2'd1,
    StGameOver = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [CW-1:0] combo_q, combo_d;

  logic start_prev_q, hit_prev_q, miss_prev_q;
  logic start_edge, hit_edge, miss_edge;

  logic [8:0] inc;
  logic [8:0] sum;

  // A level held high yields exactly one event on its first sampled cycle.
  assign start_edge = start & ~start_prev_q;
  assign hit_edge   = hit & ~hit_prev_q;
  assign miss_edge  = miss & ~miss_prev_q;

  // Score arithmetic is done in 9 bits so the saturation compare sees any carry out.
  assign inc = (combo_q == ComboMax) ? IncDouble : IncSingle;
  assign sum = {1'b0, score_q} + inc;

  // Previous-sample registers for the edge detectors.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      start_prev_q <= 1'b0;
      hit_prev_q   <= 1'b0;
      miss_prev_q  <= 1'b0;
    end else begin
      start_prev_q <= start;
      hit_prev_q   <= hit;
      miss_prev_q  <= miss;
    end
  end

  // Next-state logic: start beats miss, miss beats hit.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    combo_d = combo_q;
    case (state_q)
      StIdle, StGameOver: begin
        if (start_edge) begin
          state_d = StPlaying;
          score_d = 8'd0;
          lives_d = LivesInit;
          combo_d = '0;
        end
      end
      StPlaying: begin
        if (start_edge) begin
          score_d = 8'd0;
          lives_d = LivesInit;
          combo_d = '0;
        end else if (miss_edge) begin
          combo_d = '0;
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = StGameOver;
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end else if (hit_edge) begin
          score_d = (sum > MaxScore9) ? MaxScore9[7:0] : sum[7:0];
          combo_d = (combo_q >= ComboMax) ? ComboMax : combo_q + CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Game state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      score_q <= 8'd0;
      lives_q <= 2'd0;
      combo_q <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      combo_q <= combo_d;
    end
  end

  assign score     = score_q;
  assign lives     = lives_q;
  assign playing   = (state_q == StPlaying);
  assign game_over = (state_q == StGameOver);

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [7:0] high_score_q, high_score_d;
  logic       enter_over;

  // A game ends only on a miss, which leaves score untouched, so score_q is the final score.
  assign enter_over = (state_q != StGameOver) && (state_d == StGameOver);

  // Track the best final score across games.
  always_comb begin
    high_score_d = high_score_q;
    if (enter_over && (score_q > high_score_q)) begin
      high_score_d = score_q;
    end
  end

  // High-score register; survives restarts, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      high_score_q <= 8'd0;
    end else begin
      high_score_q <= high_score_d;
    end
  end

  assign high_score = high_score_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed testbench for score_keeper: a default instance plus a MAX_SCORE=10 instance
// sharing the same stimulus.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start, hit, miss;
  logic [7:0] score, sat_score;
  logic [1:0] lives, sat_lives;
  logic       playing, game_over, sat_playing, sat_game_over;
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [7:0] high_score, sat_high_score;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_keeper u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .score     (score),
    .lives     (lives),
    .playing   (playing),
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    .game_over (game_over),
    .high_score(high_score)
`else
    .game_over (game_over)
`endif
  );

  score_keeper #(
    .MAX_SCORE (10),
    .LIVES_INIT(3),
    .POINTS_HIT(1),
    .COMBO_LEN (4)
  ) u_sat (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .score     (sat_score),
    .lives     (sat_lives),
    .playing   (sat_playing),
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    .game_over (sat_game_over),
    .high_score(sat_high_score)
`else
    .game_over (sat_game_over)
`endif
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  task automatic pulse_hit();
    hit = 1'b1; tick(); hit = 1'b0; tick();
  endtask

  task automatic pulse_miss();
    miss = 1'b1; tick(); miss = 1'b0; tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b1; hit = 1'b1; miss = 1'b1;
    tick(); tick();
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d expected 0", score); end
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL reset_lives got %0d expected 0", lives); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %b expected 0", playing); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b expected 0", game_over); end
    // Release with all inputs held high: start counts as an edge, start wins over hit/miss.
    resetn = 1'b1;
    tick();
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL release_playing got %b expected 1", playing); end
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL release_lives got %0d expected 3", lives); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL release_score got %0d expected 0", score); end
    tick(); tick();
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL held_miss_lives got %0d expected 3", lives); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL held_hit_score got %0d expected 0", score); end
    start = 1'b0; hit = 1'b0; miss = 1'b0;
    tick();
  endtask

  task automatic test_combo();
    logic [7:0] exp_seq [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8};
    pulse_start();
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL combo_start_score got %0d expected 0", score); end
    for (int i = 0; i < 6; i++) begin
      pulse_hit();
      checks++;
      if (score !== exp_seq[i]) begin
        errors++; $display("FAIL combo_hit%0d got %0d expected %0d", i, score, exp_seq[i]);
      end
    end
  endtask

  task automatic test_hit_miss();
    logic [7:0] exp_seq [5] = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd9};
    pulse_start();
    pulse_hit(); pulse_hit(); pulse_hit();
    checks++; if (score !== 8'd3) begin errors++; $display("FAIL hm_pre_score got %0d expected 3", score); end
    hit = 1'b1; miss = 1'b1; tick();
    checks++; if (score !== 8'd3) begin errors++; $display("FAIL hm_same_score got %0d expected 3", score); end
    checks++; if (lives !== 2'd2) begin errors++; $display("FAIL hm_same_lives got %0d expected 2", lives); end
    hit = 1'b0; miss = 1'b0; tick();
    // Combo restarts from zero: four single-point hits before the bonus returns.
    for (int i = 0; i < 5; i++) begin
      pulse_hit();
      checks++;
      if (score !== exp_seq[i]) begin
        errors++; $display("FAIL hm_after%0d got %0d expected %0d", i, score, exp_seq[i]);
      end
    end
  endtask

  task automatic test_game_over();
    logic [1:0] exp_lives [3] = '{2'd2, 2'd1, 2'd0};
    pulse_start();
    pulse_hit(); pulse_hit();
    for (int i = 0; i < 3; i++) begin
      pulse_miss();
      checks++;
      if (lives !== exp_lives[i]) begin
        errors++; $display("FAIL go_lives%0d got %0d expected %0d", i, lives, exp_lives[i]);
      end
    end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_flag got %b expected 1", game_over); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL go_playing got %b expected 0", playing); end
    pulse_hit(); pulse_miss();
    checks++; if (score !== 8'd2) begin errors++; $display("FAIL go_hold_score got %0d expected 2", score); end
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL go_hold_lives got %0d expected 0", lives); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_hold_flag got %b expected 1", game_over); end
  endtask

  task automatic test_restart();
    pulse_start();
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL rs_playing got %b expected 1", playing); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL rs_game_over got %b expected 0", game_over); end
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL rs_lives got %0d expected 3", lives); end
    pulse_hit(); pulse_hit(); pulse_miss();
    // Restart together with hit and miss: restart wins and clears everything.
    start = 1'b1; hit = 1'b1; miss = 1'b1; tick();
    start = 1'b0; hit = 1'b0; miss = 1'b0; tick();
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL rs_mid_score got %0d expected 0", score); end
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL rs_mid_lives got %0d expected 3", lives); end
    pulse_hit();
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL rs_first_hit got %0d expected 1", score); end
  endtask

  task automatic test_back_to_back();
    // A hit held high for several cycles is a single event.
    hit = 1'b1; tick(); tick(); tick();
    hit = 1'b0; tick();
    checks++; if (score !== 8'd2) begin errors++; $display("FAIL held_hit got %0d expected 2", score); end
  endtask

  task automatic test_saturate();
    pulse_start();
    pulse_hit(); pulse_hit(); pulse_hit();
    pulse_miss();
    for (int i = 0; i < 5; i++) pulse_hit();
    checks++; if (sat_score !== 8'd9) begin errors++; $display("FAIL sat_pre got %0d expected 9", sat_score); end
    checks++; if (score !== 8'd9) begin errors++; $display("FAIL nosat_pre got %0d expected 9", score); end
    pulse_hit();
    checks++; if (sat_score !== 8'd10) begin errors++; $display("FAIL sat_clamp got %0d expected 10", sat_score); end
    checks++; if (score !== 8'd11) begin errors++; $display("FAIL nosat_next got %0d expected 11", score); end
    pulse_hit();
    checks++; if (sat_score !== 8'd10) begin errors++; $display("FAIL sat_hold got %0d expected 10", sat_score); end
    checks++; if (sat_lives !== 2'd2) begin errors++; $display("FAIL sat_lives got %0d expected 2", sat_lives); end
  endtask

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  task automatic test_high_score();
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    checks++; if (high_score !== 8'd0) begin errors++; $display("FAIL hs_reset got %0d expected 0", high_score); end
    // Game 1: 1,2,3,4,6, miss, 7, miss, miss.
    pulse_start();
    for (int i = 0; i < 5; i++) pulse_hit();
    pulse_miss(); pulse_hit(); pulse_miss(); pulse_miss();
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL hs_g1_over got %b expected 1", game_over); end
    checks++; if (high_score !== 8'd7) begin errors++; $display("FAIL hs_g1 got %0d expected 7", high_score); end
    // Game 2: 1,2,3,4, miss, 5, miss, miss.
    pulse_start();
    checks++; if (high_score !== 8'd7) begin errors++; $display("FAIL hs_restart got %0d expected 7", high_score); end
    for (int i = 0; i < 4; i++) pulse_hit();
    pulse_miss(); pulse_hit(); pulse_miss(); pulse_miss();
    checks++; if (score !== 8'd5) begin errors++; $display("FAIL hs_g2_score got %0d expected 5", score); end
    checks++; if (high_score !== 8'd7) begin errors++; $display("FAIL hs_g2 got %0d expected 7", high_score); end
    resetn = 1'b0; tick();
    checks++; if (high_score !== 8'd0) begin errors++; $display("FAIL hs_clear got %0d expected 0", high_score); end
    resetn = 1'b1; tick();
  endtask
`endif

  initial begin
    test_reset();
    test_combo();
    test_hit_miss();
    test_game_over();
    test_restart();
    test_back_to_back();
    test_saturate();
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    test_high_score();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
